mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use clock in_CLK and reset in_CLR, where in_CLR is asynchronous and active-high.
REQ-002 Ports SHALL be:
- in_CLK  in  1  clock
- in_CLR  in  1  async reset
- in_EN  in  1  stage advance; 0 = stall
- in_lock  in  1  lock flag from EX/MEM
- in_is  in  32  instruction
- in_pcout  in  32  PC+4
- in_R  in  32  ALU result / byte address
- in_rb  in  32  store data
- in_p4  in  5  destination register number
- in_control  in  26  control word
- out_lock  out  1  registered in_lock
- out_is  out  32  registered in_is
- out_pcout  out  32  registered in_pcout
- out_R  out  32  registered in_R
- out_D  out  32  load data, extended
- out_WD  out  32  write-back value
- out_p4  out  5  registered in_p4
- out_control  out  26  registered in_control
- out_misalign  out  1  registered misaligned-access flag
- out_ldcnt  out  16  committed-load counter
- out_stcnt  out  16  committed-store counter

REQ-003 in_control fields SHALL be:
- [0] MemWrite
- [1] MemRead
- [3:2] Size: 00 word, 01 half, 10 byte, 11 word
- [4] LoadUnsigned
- [6] MemToReg
- all other bits pass-through only

Function
REQ-004 Data memory SHALL be 1024 x 32-bit words, indexed by in_R[11:2]; in_R[31:12] is ignored.
REQ-005 A store SHALL write on the in_CLK rising edge only when in_EN=1, MemWrite=1, in_CLR=0 and the access is not misaligned.
REQ-006 Store byte lanes SHALL be:
- word: all four lanes
- half: lanes selected by in_R[1]
- byte: lane selected by in_R[1:0]
- store data: in_rb low bits replicated into the selected lane(s), little-endian
REQ-007 Misaligned SHALL mean a word access with in_R[1:0]!=0, or a half access with in_R[0]=1; misalignment is evaluated only when MemRead or MemWrite is set.
REQ-008 The load value SHALL be the lane(s) selected as in REQ-006, shifted to bit 0, then sign-extended, or zero-extended when LoadUnsigned=1.
REQ-009 A misaligned load SHALL return 0.
REQ-010 The memory read SHALL be combinational from the array contents before the current edge, and the result SHALL be registered into out_D.
REQ-011 Load latency SHALL be one cycle: out_D is valid the cycle after the load is presented with in_EN=1.
REQ-012 A load issued in the cycle after a store to the same word SHALL return the newly stored data.
REQ-013 A load and a store in the same cycle cannot occur, because MemRead=1 and MemWrite=1 together is illegal; if both are asserted, the store SHALL be performed and out_D SHALL receive the pre-store data.
REQ-014 out_WD SHALL be registered as the load value when MemToReg=1, else in_R.
REQ-015 On each rising edge with in_EN=1, every out_* register SHALL load its next value.
REQ-016 With in_EN=0, all outputs SHALL hold, no memory write SHALL occur, and the counters SHALL hold.
REQ-017 out_misalign SHALL be registered with in_EN=1 and SHALL be 1 for exactly the cycles whose captured access was misaligned.
REQ-018 out_ldcnt SHALL increment by 1 per committed aligned load.
REQ-019 out_stcnt SHALL increment by 1 per committed aligned store.
REQ-020 Both counters SHALL wrap from 16'hFFFF to 0.

Reset
REQ-021 While in_CLR=1, all out_* SHALL be 0 immediately, independent of in_CLK.
REQ-022 While in_CLR=1, no memory write SHALL occur.
REQ-023 in_CLR SHALL NOT clear memory contents; memory contents SHALL initialise to 0 at power-up only.
REQ-024 If in_CLR asserts during a store cycle before the edge, the store SHALL be discarded.
REQ-025 The first edge after in_CLR deasserts SHALL behave as a normal cycle.

Configuration
REQ-026 With macro MEM_SUBWORD_EN defined, half/byte accesses, extension and misalign detection SHALL be implemented as specified above.
REQ-027 Without MEM_SUBWORD_EN, all accesses SHALL be whole-word, in_R[1:0], Size and LoadUnsigned SHALL be ignored, and out_misalign SHALL be constant 0.

Verification
REQ-028 Word store then load: store 32'hDEADBEEF to address 0x10 with EN=1, then load 0x10 next cycle -> out_D=32'hDEADBEEF and out_WD=32'hDEADBEEF; out_stcnt=1, out_ldcnt=1.
REQ-029 Byte/half extension (MEM_SUBWORD_EN): word 0x10=32'h80FF7F01; load byte at 0x13 -> 32'hFFFFFF80; load byte unsigned at 0x13 -> 32'h00000080; load half at 0x12 -> 32'hFFFF80FF.
REQ-030 Misaligned store: word store 32'h12345678 at 0x21 -> out_misalign=1 for one cycle, word 0x20 unchanged, out_stcnt unchanged.
REQ-031 Stall: EN=0 during a store to 0x30 -> memory unchanged and outputs held; EN=1 on the next edge -> write performed.
REQ-032 Async reset mid-operation: assert in_CLR between edges during a store -> all outputs 0 at once, no write to the target word, and memory elsewhere preserved.
REQ-033 Counter wrap: preload out_ldcnt to 16'hFFFF via 65535 loads, then one more load -> out_ldcnt=0.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Pipeline bus between EX/MEM and MEM/WB for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        in_EN;
    logic        in_lock;
    logic [31:0] in_is;
    logic [31:0] in_pcout;
    logic [31:0] in_R;
    logic [31:0] in_rb;
    logic [4:0]  in_p4;
    logic [25:0] in_control;

    logic        out_lock;
    logic [31:0] out_is;
    logic [31:0] out_pcout;
    logic [31:0] out_R;
    logic [31:0] out_D;
    logic [31:0] out_WD;
    logic [4:0]  out_p4;
    logic [25:0] out_control;
    logic        out_misalign;
    logic [15:0] out_ldcnt;
    logic [15:0] out_stcnt;

    modport master (
        output in_EN, in_lock, in_is, in_pcout, in_R, in_rb, in_p4, in_control,
        input  out_lock, out_is, out_pcout, out_R, out_D, out_WD, out_p4,
               out_control, out_misalign, out_ldcnt, out_stcnt
    );

    modport slave (
        input  in_EN, in_lock, in_is, in_pcout, in_R, in_rb, in_p4, in_control,
        output out_lock, out_is, out_pcout, out_R, out_D, out_WD, out_p4,
               out_control, out_misalign, out_ldcnt, out_stcnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage with 1024x32 data memory, registered
//                load/write-back path and committed load/store counters.
//                Define MEM_SUBWORD_EN for half/byte accesses, load extension
//                and misalignment detection; otherwise all accesses are words.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  wire logic  in_CLK,
    input  wire logic  in_CLR,
    mem_stage_if.slave bus
);
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    // Contents survive in_CLR; only power-up clears them.
    logic [31:0] r_mem [0:DEPTH-1] = '{default: 32'h0};

    logic          w_mem_wr;
    logic          w_mem_rd;
    logic          w_mem_to_reg;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_rdata;
    logic [31:0]   w_wmask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic          w_misalign;
    logic [31:0]   w_wd_next;
    logic          w_commit_ld;
    logic          w_commit_st;

    logic          r_lock;
    logic [31:0]   r_is;
    logic [31:0]   r_pcout;
    logic [31:0]   r_R;
    logic [31:0]   r_D;
    logic [31:0]   r_WD;
    logic [4:0]    r_p4;
    logic [25:0]   r_control;
    logic          r_misalign;
    logic [15:0]   r_ldcnt;
    logic [15:0]   r_stcnt;

    assign w_mem_wr     = bus.in_control[0];
    assign w_mem_rd     = bus.in_control[1];
    assign w_mem_to_reg = bus.in_control[6];
    assign w_addr       = bus.in_R[11:2];
    assign w_rdata      = r_mem[w_addr];

`ifdef MEM_SUBWORD_EN
    logic [1:0]  w_size;
    logic        w_load_uns;
    logic        w_access;
    logic [31:0] w_lane;
    logic        w_unused_lane;

    assign w_size        = bus.in_control[3:2];
    assign w_load_uns    = bus.in_control[4];
    assign w_access      = w_mem_rd | w_mem_wr;
    assign w_unused_lane = ^w_lane[31:16];

    always_comb begin
        w_wmask    = 32'hFFFF_FFFF;
        w_wdata    = bus.in_rb;
        w_lane     = w_rdata;
        w_load     = w_rdata;
        w_misalign = 1'b0;
        case (w_size)
            2'b10: begin
                w_wmask = 32'h0000_00FF << {bus.in_R[1:0], 3'b000};
                w_wdata = {4{bus.in_rb[7:0]}};
                w_lane  = w_rdata >> {bus.in_R[1:0], 3'b000};
                w_load  = w_load_uns ? {24'h0, w_lane[7:0]}
                                     : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                w_wmask    = bus.in_R[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wdata    = {2{bus.in_rb[15:0]}};
                w_lane     = w_rdata >> {bus.in_R[1], 4'b0000};
                w_load     = w_load_uns ? {16'h0, w_lane[15:0]}
                                        : {{16{w_lane[15]}}, w_lane[15:0]};
                w_misalign = w_access & bus.in_R[0];
            end
            default: begin
                w_misalign = w_access & (bus.in_R[1:0] != 2'b00);
            end
        endcase
        if (w_misalign) begin
            w_load = 32'h0;
        end
    end
`else
    always_comb begin
        w_wmask    = 32'hFFFF_FFFF;
        w_wdata    = bus.in_rb;
        w_load     = w_rdata;
        w_misalign = 1'b0;
    end
`endif

    assign w_wd_next   = w_mem_to_reg ? w_load : bus.in_R;
    assign w_commit_ld = bus.in_EN & w_mem_rd & ~w_misalign;
    assign w_commit_st = bus.in_EN & w_mem_wr & ~w_misalign;

    // Read-modify-write merge keeps unselected lanes; reset suppresses the write.
    always_ff @(posedge in_CLK) begin
        if (!in_CLR && w_commit_st) begin
            r_mem[w_addr] <= (w_rdata & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    always_ff @(posedge in_CLK or posedge in_CLR) begin
        if (in_CLR) begin
            r_lock     <= 1'b0;
            r_is       <= 32'h0;
            r_pcout    <= 32'h0;
            r_R        <= 32'h0;
            r_D        <= 32'h0;
            r_WD       <= 32'h0;
            r_p4       <= 5'h0;
            r_control  <= 26'h0;
            r_misalign <= 1'b0;
            r_ldcnt    <= 16'h0;
            r_stcnt    <= 16'h0;
        end else if (bus.in_EN) begin
            r_lock     <= bus.in_lock;
            r_is       <= bus.in_is;
            r_pcout    <= bus.in_pcout;
            r_R        <= bus.in_R;
            r_D        <= w_load;
            r_WD       <= w_wd_next;
            r_p4       <= bus.in_p4;
            r_control  <= bus.in_control;
            r_misalign <= w_misalign;
            if (w_commit_ld) begin
                r_ldcnt <= r_ldcnt + 16'd1;
            end
            if (w_commit_st) begin
                r_stcnt <= r_stcnt + 16'd1;
            end
        end
    end

    assign bus.out_lock     = r_lock;
    assign bus.out_is       = r_is;
    assign bus.out_pcout    = r_pcout;
    assign bus.out_R        = r_R;
    assign bus.out_D        = r_D;
    assign bus.out_WD       = r_WD;
    assign bus.out_p4       = r_p4;
    assign bus.out_control  = r_control;
    assign bus.out_misalign = r_misalign;
    assign bus.out_ldcnt    = r_ldcnt;
    assign bus.out_stcnt    = r_stcnt;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard bench for mem_stage with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    localparam logic [25:0] C_SW   = 26'h01;
    localparam logic [25:0] C_LW   = 26'h42;
    localparam logic [25:0] C_SB   = 26'h09;
    localparam logic [25:0] C_LB   = 26'h4A;
    localparam logic [25:0] C_LBU  = 26'h5A;
    localparam logic [25:0] C_LH   = 26'h46;
    localparam logic [25:0] C_LDST = 26'h43;

    logic in_CLK;
    logic in_CLR;
    mem_stage_if bus ();

    mem_stage dut (
        .in_CLK (in_CLK),
        .in_CLR (in_CLR),
        .bus    (bus)
    );

    typedef struct {
        int          due;
        string       nm;
        bit          chk_dw;
        logic [31:0] d;
        logic [31:0] wd;
        logic        mis;
        logic [15:0] ld;
        logic [15:0] st;
        bit          chk_pt;
        logic [31:0] is;
        logic [31:0] pc;
        logic [4:0]  p4;
        logic        lock;
        logic [25:0] ctl;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_ld = 16'h0;
    logic [15:0] exp_st = 16'h0;
    logic        last_mis = 1'b0;

    initial in_CLK = 1'b0;
    always #5 in_CLK = ~in_CLK;
    always @(posedge in_CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    always @(negedge in_CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_total++;
                $display("FAIL %s: entry due cycle %0d, seen %0d", e.nm, e.due, cyc);
            end else begin
                if (e.chk_dw) begin
                    check32({e.nm, "/D"}, bus.out_D, e.d);
                    check32({e.nm, "/WD"}, bus.out_WD, e.wd);
                end
                check32({e.nm, "/mis"}, {31'h0, bus.out_misalign}, {31'h0, e.mis});
                check32({e.nm, "/ldcnt"}, {16'h0, bus.out_ldcnt}, {16'h0, e.ld});
                check32({e.nm, "/stcnt"}, {16'h0, bus.out_stcnt}, {16'h0, e.st});
                if (e.chk_pt) begin
                    check32({e.nm, "/is"}, bus.out_is, e.is);
                    check32({e.nm, "/pc"}, bus.out_pcout, e.pc);
                    check32({e.nm, "/p4"}, {27'h0, bus.out_p4}, {27'h0, e.p4});
                    check32({e.nm, "/lock"}, {31'h0, bus.out_lock}, {31'h0, e.lock});
                    check32({e.nm, "/ctl"}, {6'h0, bus.out_control}, {6'h0, e.ctl});
                end
            end
        end
    end

    task automatic op(input string nm, input logic en, input logic [25:0] ctl,
                      input logic [31:0] addr, input logic [31:0] rb,
                      input bit chk_dw, input logic [31:0] ed, input logic [31:0] ewd,
                      input logic emis, input bit pt, input bit push);
        exp_t e;
        @(posedge in_CLK);
        #2;
        bus.in_EN      = en;
        bus.in_control = pt ? (ctl | 26'h200_0000) : ctl;
        bus.in_R       = addr;
        bus.in_rb      = rb;
        bus.in_is      = pt ? 32'h1122_3344 : 32'h0;
        bus.in_pcout   = pt ? 32'h0000_1004 : 32'h0;
        bus.in_p4      = pt ? 5'd17 : 5'd0;
        bus.in_lock    = pt;
        if (en) begin
            last_mis = emis;
            if (ctl[1] && !emis) exp_ld = exp_ld + 16'd1;
            if (ctl[0] && !emis) exp_st = exp_st + 16'd1;
        end
        if (push) begin
            e.due    = cyc + 1;
            e.nm     = nm;
            e.chk_dw = chk_dw;
            e.d      = ed;
            e.wd     = ewd;
            e.mis    = last_mis;
            e.ld     = exp_ld;
            e.st     = exp_st;
            e.chk_pt = pt;
            e.is     = 32'h1122_3344;
            e.pc     = 32'h0000_1004;
            e.p4     = 5'd17;
            e.lock   = 1'b1;
            e.ctl    = ctl | 26'h200_0000;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        @(posedge in_CLK);
        #2;
        bus.in_EN = 1'b0;
        for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge in_CLK);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            $display("FAIL %s: expected output never observed", e.nm);
        end
    endtask

    task automatic check_zero(input string tag);
        check32({tag, "/D"}, bus.out_D, 32'h0);
        check32({tag, "/WD"}, bus.out_WD, 32'h0);
        check32({tag, "/R"}, bus.out_R, 32'h0);
        check32({tag, "/is"}, bus.out_is, 32'h0);
        check32({tag, "/pc"}, bus.out_pcout, 32'h0);
        check32({tag, "/ctl"}, {6'h0, bus.out_control}, 32'h0);
        check32({tag, "/misc"}, {25'h0, bus.out_p4, bus.out_lock, bus.out_misalign}, 32'h0);
        check32({tag, "/cnt"}, {bus.out_ldcnt, bus.out_stcnt}, 32'h0);
    endtask

    task automatic clean_reset(input string tag);
        drain();
        @(posedge in_CLK);
        #2;
        in_CLR = 1'b1;
        #1;
        check_zero(tag);
        @(posedge in_CLK);
        #2;
        in_CLR = 1'b0;
        exp_ld = 16'h0;
        exp_st = 16'h0;
        last_mis = 1'b0;
    endtask

    initial begin
        in_CLR = 1'b1;
        bus.in_EN = 1'b0; bus.in_lock = 1'b0; bus.in_is = 32'h0; bus.in_pcout = 32'h0;
        bus.in_R = 32'h0; bus.in_rb = 32'h0; bus.in_p4 = 5'h0; bus.in_control = 26'h0;
        #3;
        check_zero("por");
        @(posedge in_CLK);
        #2;
        in_CLR = 1'b0;

        op("sw10",  1, C_SW, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 32'h10, 0, 1, 1);
        op("lw10",  1, C_LW, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1);
        op("sw10b", 1, C_SW, 32'h10, 32'h80FF_7F01, 1, 32'hDEAD_BEEF, 32'h10, 0, 0, 1);
`ifdef MEM_SUBWORD_EN
        op("lb13",  1, C_LB,  32'h13, 32'h0, 1, 32'hFFFF_FF80, 32'hFFFF_FF80, 0, 0, 1);
        op("lbu13", 1, C_LBU, 32'h13, 32'h0, 1, 32'h0000_0080, 32'h0000_0080, 0, 0, 1);
        op("lh12",  1, C_LH,  32'h12, 32'h0, 1, 32'hFFFF_80FF, 32'hFFFF_80FF, 0, 0, 1);
        op("sb11",  1, C_SB,  32'h11, 32'hAA, 1, 32'h0000_007F, 32'h11, 0, 0, 1);
        op("lw10c", 1, C_LW,  32'h10, 32'h0, 1, 32'h80FF_AA01, 32'h80FF_AA01, 0, 0, 1);
        op("lwmis", 1, C_LW,  32'h12, 32'h0, 1, 32'h0, 32'h0, 1, 0, 1);
        op("swmis", 1, C_SW,  32'h21, 32'h1234_5678, 1, 32'h0, 32'h21, 1, 0, 1);
        op("lw20",  1, C_LW,  32'h20, 32'h0, 1, 32'h0, 32'h0, 0, 0, 1);
        op("stall", 0, C_SW,  32'h30, 32'hCAFE_F00D, 1, 32'h0, 32'h0, 0, 0, 1);
`else
        op("lb13w", 1, C_LB,  32'h13, 32'h0, 1, 32'h80FF_7F01, 32'h80FF_7F01, 0, 0, 1);
        op("sb11w", 1, C_SB,  32'h11, 32'hAA, 1, 32'h80FF_7F01, 32'h11, 0, 0, 1);
        op("lw10c", 1, C_LW,  32'h10, 32'h0, 1, 32'h0000_00AA, 32'h0000_00AA, 0, 0, 1);
        op("lw12w", 1, C_LW,  32'h12, 32'h0, 1, 32'h0000_00AA, 32'h0000_00AA, 0, 0, 1);
        op("sw21w", 1, C_SW,  32'h21, 32'h1234_5678, 1, 32'h0, 32'h21, 0, 0, 1);
        op("lw20",  1, C_LW,  32'h20, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, 0, 0, 1);
        op("stall", 0, C_SW,  32'h30, 32'hCAFE_F00D, 1, 32'h1234_5678, 32'h1234_5678, 0, 0, 1);
`endif
        op("lw30a", 1, C_LW,   32'h30, 32'h0, 1, 32'h0, 32'h0, 0, 0, 1);
        op("sw30",  1, C_SW,   32'h30, 32'hCAFE_F00D, 1, 32'h0, 32'h30, 0, 0, 1);
        op("lw30b", 1, C_LW,   32'h30, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 1);
        op("ldst",  1, C_LDST, 32'h40, 32'h55AA_55AA, 1, 32'h0, 32'h0, 0, 0, 1);
        op("lw40",  1, C_LW,   32'h40, 32'h0, 1, 32'h55AA_55AA, 32'h55AA_55AA, 0, 0, 1);
        op("sw50",  1, C_SW,   32'h50, 32'h1111_1111, 1, 32'h0, 32'h50, 0, 0, 1);
        drain();

        // Reset lands between edges while a store to 0x50 is being presented.
        @(posedge in_CLK);
        #2;
        bus.in_EN = 1'b1; bus.in_control = C_SW; bus.in_R = 32'h50; bus.in_rb = 32'h2222_2222;
        #2;
        in_CLR = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge in_CLK);
        #2;
        in_CLR = 1'b0;
        bus.in_EN = 1'b0;
        exp_ld = 16'h0;
        exp_st = 16'h0;
        last_mis = 1'b0;
        op("lw50r", 1, C_LW, 32'h50, 32'h0, 1, 32'h1111_1111, 32'h1111_1111, 0, 0, 1);
`ifdef MEM_SUBWORD_EN
        op("lw10r", 1, C_LW, 32'h10, 32'h0, 1, 32'h80FF_AA01, 32'h80FF_AA01, 0, 0, 1);
`else
        op("lw10r", 1, C_LW, 32'h10, 32'h0, 1, 32'h0000_00AA, 32'h0000_00AA, 0, 0, 1);
`endif
        clean_reset("rst2");

        for (int i = 0; i < 65534; i++) begin
            op("fill", 1, C_LW, 32'h50, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        end
        op("ldffff", 1, C_LW, 32'h50, 32'h0, 1, 32'h1111_1111, 32'h1111_1111, 0, 0, 1);
        op("ldwrap", 1, C_LW, 32'h50, 32'h0, 1, 32'h1111_1111, 32'h1111_1111, 0, 0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
